// File: rtl/index_dispatch_buffer_if.sv
// Handshake bundle for index_dispatch_buffer: encoded request in, one-hot lanes out.
// The master modport is the surrounding environment, which is both producer and consumers.
interface index_dispatch_buffer_if #(
  parameter int N     = 4,
  parameter int DATAW = 32,
  parameter int LN    = (N > 1) ? $clog2(N) : 1
);
  logic             valid_in;
  logic [LN-1:0]    index_in;
  logic [DATAW-1:0] data_in;
  logic             ready_in;
  logic [N-1:0]     valid_out;
  logic [DATAW-1:0] data_out;
  logic [N-1:0]     ready_out;

  modport master (
    output valid_in, index_in, data_in, ready_out,
    input  ready_in, valid_out, data_out
  );
  modport slave (
    input  valid_in, index_in, data_in, ready_out,
    output ready_in, valid_out, data_out
  );
endinterface

// File: rtl/index_dispatch_buffer.sv
// Index-to-one-hot dispatch with a main+skid elastic buffer; ready_in is purely registered.
// Entries hold the destination as a one-hot vector so valid_out comes straight from a flop.

module index_dispatch_lane #(
  parameter int LN   = 2,
  parameter int LANE = 0,
  parameter bit ANY  = 1'b0
) (
  input  logic [LN-1:0] idx,
  input  logic          head,
  input  logic          rdy,
  output logic          sel,
  output logic          fire
);
  assign sel  = ANY ? 1'b1 : (idx == LN'(LANE));
  assign fire = head & rdy;
endmodule

module index_dispatch_buffer #(
  parameter int N     = 4,
  parameter int DATAW = 32,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  index_dispatch_buffer_if.slave bus,
  output logic                   err_out,
  output logic [CNTW-1:0]        drop_count
);
  localparam int LN = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     main_oh_q, main_oh_d, skid_oh_q, skid_oh_d;
  logic [N-1:0]     in_oh, lane_fire;
  logic [DATAW-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic             err_q, err_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             main_valid, skid_valid, in_fire, store, drop, out_fire;

  for (genvar i = 0; i < N; i++) begin : g_lane
    index_dispatch_lane #(.LN(LN), .LANE(i), .ANY(N == 1)) u_lane (
      .idx  (bus.index_in),
      .head (main_oh_q[i]),
      .rdy  (bus.ready_out[i]),
      .sel  (in_oh[i]),
      .fire (lane_fire[i])
    );
  end

  assign main_valid = |main_oh_q;
  assign skid_valid = |skid_oh_q;
  assign out_fire   = |lane_fire;
  assign in_fire    = bus.valid_in & ~skid_valid;
  // An out-of-range index decodes to no lane at all, which is what marks it for dropping.
  assign store      = in_fire & (|in_oh);
  assign drop       = in_fire & ~(|in_oh);

  always_comb begin
    main_oh_d   = main_oh_q;
    main_data_d = main_data_q;
    skid_oh_d   = skid_oh_q;
    skid_data_d = skid_data_q;
    if (out_fire) begin
      if (skid_valid) begin
        main_oh_d   = skid_oh_q;
        main_data_d = skid_data_q;
        skid_oh_d   = store ? in_oh : '0;
        skid_data_d = bus.data_in;
      end else if (store) begin
        main_oh_d   = in_oh;
        main_data_d = bus.data_in;
      end else begin
        main_oh_d   = '0;
      end
    end else if (store) begin
      if (!main_valid) begin
        main_oh_d   = in_oh;
        main_data_d = bus.data_in;
      end else begin
        skid_oh_d   = in_oh;
        skid_data_d = bus.data_in;
      end
    end
    err_d = drop;
    cnt_d = (drop && !(&cnt_q)) ? cnt_q + CNTW'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_oh_q <= '0;
      skid_oh_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      main_oh_q <= main_oh_d;
      skid_oh_q <= skid_oh_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Payload is qualified by the one-hot vectors, so it needs no reset.
  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end

  assign bus.ready_in  = ~skid_valid;
  assign bus.valid_out = main_oh_q;
  assign bus.data_out  = main_data_q;
  assign err_out       = err_q;
  assign drop_count    = cnt_q;

  a_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(main_oh_q));
  a_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (main_valid && !out_fire) |=> ($stable(bus.data_out) && $stable(bus.valid_out)));
  a_skid:   assert property (@(posedge clk) disable iff (!reset_n) skid_valid |-> main_valid);
endmodule

// File: tb/tb_index_dispatch_buffer.sv
// Bench for index_dispatch_buffer: N=4 instance for lane behaviour, N=5/CNTW=2 for drops.
module tb_index_dispatch_buffer;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  index_dispatch_buffer_if #(.N(4), .DATAW(32)) ifa ();
  index_dispatch_buffer_if #(.N(5), .DATAW(32)) ifb ();
  logic        err_a, err_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  index_dispatch_buffer #(.N(4), .DATAW(32), .CNTW(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa), .err_out(err_a), .drop_count(cnt_a));
  index_dispatch_buffer #(.N(5), .DATAW(32), .CNTW(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb), .err_out(err_b), .drop_count(cnt_b));

  typedef struct { int lane; logic [31:0] data; } exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int total = 0, bad = 0;

  // scoreboards: every output transfer must match the oldest accepted in-range request
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (ifa.valid_out & ifa.ready_out) != 4'b0) begin
      total++;
      if (qa.size() == 0) begin
        bad++; $display("FAIL sb_a: got lanes=%b data=%h, required no transfer", ifa.valid_out, ifa.data_out);
      end else begin
        ea = qa.pop_front();
        if (ifa.valid_out !== 4'(1 << ea.lane) || ifa.data_out !== ea.data) begin
          bad++; $display("FAIL sb_a: got lanes=%b data=%h, required lanes=%b data=%h",
                          ifa.valid_out, ifa.data_out, 4'(1 << ea.lane), ea.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1 && (ifb.valid_out & ifb.ready_out) != 5'b0) begin
      total++;
      if (qb.size() == 0) begin
        bad++; $display("FAIL sb_b: got lanes=%b data=%h, required no transfer", ifb.valid_out, ifb.data_out);
      end else begin
        eb = qb.pop_front();
        if (ifb.valid_out !== 5'(1 << eb.lane) || ifb.data_out !== eb.data) begin
          bad++; $display("FAIL sb_b: got lanes=%b data=%h, required lanes=%b data=%h",
                          ifb.valid_out, ifb.data_out, 5'(1 << eb.lane), eb.data);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_a(input int idx, input logic [31:0] d);
    int n = 0;
    ifa.valid_in = 1'b1; ifa.index_in = 2'(idx); ifa.data_in = d;
    while (ifa.ready_in !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      total++; bad++; $display("FAIL send_a_timeout: ready_in=%b, required 1", ifa.ready_in);
      ifa.valid_in = 1'b0; return;
    end
    qa.push_back('{lane: idx, data: d});
    @(posedge clk); #1;
    ifa.valid_in = 1'b0;
  endtask

  task automatic send_b(input int idx, input logic [31:0] d);
    int n = 0;
    ifb.valid_in = 1'b1; ifb.index_in = 3'(idx); ifb.data_in = d;
    while (ifb.ready_in !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      total++; bad++; $display("FAIL send_b_timeout: ready_in=%b, required 1", ifb.ready_in);
      ifb.valid_in = 1'b0; return;
    end
    if (idx < 5) qb.push_back('{lane: idx, data: d});
    @(posedge clk); #1;
    ifb.valid_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ifa.valid_in = 0; ifa.index_in = '0; ifa.data_in = '0; ifa.ready_out = 4'hF;
    ifb.valid_in = 0; ifb.index_in = '0; ifb.data_in = '0; ifb.ready_out = 5'h1F;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ifa.valid_out !== 4'b0) begin bad++; $display("FAIL rst_valid_a: got %b want 0000", ifa.valid_out); end
    total++; if (ifa.ready_in !== 1'b1) begin bad++; $display("FAIL rst_ready_a: got %b want 1", ifa.ready_in); end
    total++; if (cnt_a !== 16'd0 || err_a !== 1'b0) begin bad++; $display("FAIL rst_cnt_a: got cnt=%0d err=%b want 0 0", cnt_a, err_a); end
    total++; if (ifb.valid_out !== 5'b0 || cnt_b !== 2'd0) begin bad++; $display("FAIL rst_b: got v=%b cnt=%0d want 0 0", ifb.valid_out, cnt_b); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    send_a(2, 32'hA5);
    total++; if (ifa.valid_out !== 4'b0100 || ifa.data_out !== 32'hA5) begin
      bad++; $display("FAIL single: got v=%b d=%h want 0100 a5", ifa.valid_out, ifa.data_out); end
    @(posedge clk); #1;
    total++; if (ifa.valid_out !== 4'b0) begin bad++; $display("FAIL single_once: got %b want 0000", ifa.valid_out); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      ifa.valid_in = 1'b1; ifa.index_in = 2'(i); ifa.data_in = 32'h10 + 32'(i);
      total++; if (ifa.ready_in !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", ifa.ready_in); end
      qa.push_back('{lane: i, data: 32'h10 + 32'(i)});
      @(posedge clk); #1;
      total++; if (ifa.valid_out !== 4'(1 << i) || ifa.data_out !== 32'h10 + 32'(i)) begin
        bad++; $display("FAIL b2b_out%0d: got v=%b d=%h want %b %h", i, ifa.valid_out, ifa.data_out, 4'(1 << i), 32'h10 + 32'(i)); end
    end
    ifa.valid_in = 1'b0;
    @(posedge clk); #1;
    total++; if (ifa.valid_out !== 4'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0000", ifa.valid_out); end
  endtask

  task automatic test_lane_stall();
    ifa.ready_out = 4'b1101;
    send_a(1, 32'h20);
    send_a(3, 32'h30);
    total++; if (ifa.ready_in !== 1'b0) begin bad++; $display("FAIL stall_full: ready_in got %b want 0", ifa.ready_in); end
    ifa.valid_in = 1'b1; ifa.index_in = 2'd0; ifa.data_in = 32'h40;
    repeat (3) begin
      @(posedge clk); #1;
      total++; if (ifa.valid_out !== 4'b0010 || ifa.data_out !== 32'h20 || ifa.ready_in !== 1'b0) begin
        bad++; $display("FAIL stall_hold: got v=%b d=%h rdy=%b want 0010 20 0", ifa.valid_out, ifa.data_out, ifa.ready_in); end
    end
    ifa.ready_out = 4'hF;
    @(posedge clk); #1;
    total++; if (ifa.valid_out !== 4'b1000 || ifa.data_out !== 32'h30 || ifa.ready_in !== 1'b1) begin
      bad++; $display("FAIL stall_drain: got v=%b d=%h rdy=%b want 1000 30 1", ifa.valid_out, ifa.data_out, ifa.ready_in); end
    qa.push_back('{lane: 0, data: 32'h40});
    @(posedge clk); #1;
    ifa.valid_in = 1'b0;
    total++; if (ifa.valid_out !== 4'b0001 || ifa.data_out !== 32'h40) begin
      bad++; $display("FAIL stall_third: got v=%b d=%h want 0001 40", ifa.valid_out, ifa.data_out); end
    @(posedge clk); #1;
    total++; if (ifa.valid_out !== 4'b0 || qa.size() != 0) begin
      bad++; $display("FAIL stall_empty: got v=%b pending=%0d want 0000 0", ifa.valid_out, qa.size()); end
  endtask

  task automatic test_out_of_range();
    send_b(6, 32'h66);
    total++; if (err_b !== 1'b1 || cnt_b !== 2'd1 || ifb.valid_out !== 5'b0) begin
      bad++; $display("FAIL oor_drop: got err=%b cnt=%0d v=%b want 1 1 00000", err_b, cnt_b, ifb.valid_out); end
    send_b(4, 32'h55);
    total++; if (ifb.valid_out !== 5'b10000 || ifb.data_out !== 32'h55 || err_b !== 1'b0) begin
      bad++; $display("FAIL oor_next: got v=%b d=%h err=%b want 10000 55 0", ifb.valid_out, ifb.data_out, err_b); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    reset_n = 1'b0; #2; reset_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 5; k++) begin
      send_b(5 + (k % 3), 32'(k));
      total++; if (err_b !== 1'b1 || cnt_b !== 2'((k < 3) ? k : 3)) begin
        bad++; $display("FAIL sat%0d: got err=%b cnt=%0d want 1 %0d", k, err_b, cnt_b, (k < 3) ? k : 3); end
    end
    @(posedge clk); #1;
    total++; if (err_b !== 1'b0 || cnt_b !== 2'd3 || ifb.valid_out !== 5'b0) begin
      bad++; $display("FAIL sat_end: got err=%b cnt=%0d v=%b want 0 3 00000", err_b, cnt_b, ifb.valid_out); end
  endtask

  task automatic test_async_reset();
    ifa.ready_out = 4'b0000;
    send_a(2, 32'h77);
    send_a(1, 32'h78);
    total++; if (ifa.ready_in !== 1'b0 || ifa.valid_out !== 4'b0100) begin
      bad++; $display("FAIL ar_full: got rdy=%b v=%b want 0 0100", ifa.ready_in, ifa.valid_out); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (ifa.valid_out !== 4'b0 || ifa.ready_in !== 1'b1) begin
      bad++; $display("FAIL ar_immediate: got v=%b rdy=%b want 0000 1", ifa.valid_out, ifa.ready_in); end
    qa.delete(); qb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    ifa.ready_out = 4'hF;
    repeat (3) begin
      @(posedge clk); #1;
      total++; if (ifa.valid_out !== 4'b0) begin bad++; $display("FAIL ar_stale: got %b want 0000", ifa.valid_out); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_lane_stall();
    test_out_of_range();
    test_saturation();
    test_async_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (qa.size() != 0 || qb.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got a=%0d b=%0d want 0 0", qa.size(), qb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/index_dispatch_buffer.md
Name: index_dispatch_buffer

Overview:
- Decode side of the priority-encoder path: takes an encoded lane index plus payload from an arbiter or scheduler and delivers the payload to exactly one of N one-hot output lanes.
- Uses a valid/ready handshake on every lane.
- Contains a two-entry elastic buffer (main register + skid register), so it sustains one transfer per cycle with fully registered outputs.
- Sits between a grant/index source and N per-lane consumers, e.g. per-warp or per-bank request queues.

Parameters:
- N, 4, number of output lanes (>=1).
- DATAW, 32, payload width in bits.
- LN, LOG2UP(N), width of the index input (derived; never overridden).
- CNTW, 16, width of the dropped-request counter.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- valid_in  input  1  request valid.
- index_in  input  LN  destination lane index.
- data_in  input  DATAW  payload.
- ready_in  output  1  buffer can accept a request.
- valid_out  output  N  one-hot lane valid; all-zero when the buffer is empty.
- data_out  output  DATAW  payload, shared by all lanes.
- ready_out  input  N  per-lane consumer ready.
- err_out  output  1  one-cycle pulse: a request was dropped for an out-of-range index.
- drop_count  output  CNTW  saturating count of dropped requests.

Behaviour:
- Reset (async assert, sync release):
  - main_valid=0, skid_valid=0, so valid_out=0 and ready_in=1.
  - err_out=0, drop_count=0.
  - Payload and index registers are not reset; their contents are don't-care while invalid.
- Handshakes:
  - Input fire: in_fire = valid_in & ready_in.
  - ready_in = ~skid_valid. It is registered state only, with no combinational path from ready_out.
  - Output fire: out_fire = main_valid & ready_out[main_idx].
  - valid_out[i] = main_valid & (main_idx == i).
- Out-of-range index (index_in >= N, possible only when N is not a power of two):
  - The request is accepted (in_fire) but not stored.
  - err_out=1 on the next cycle.
  - drop_count increments and saturates at all-ones.
  - Lane state and ordering are unaffected.
- N==1: index_in is ignored, every request targets lane 0, and no drops occur.
- Buffer update per cycle, for an in-range in_fire:
  - Main empty or out_fire, and skid empty: load main from the input.
  - Main occupied and no out_fire: load skid from the input.
  - When out_fire occurs and skid_valid=1: main loads from skid, skid clears, and the input goes to skid in the same cycle if in_fire.
  - out_fire with no replacement: main_valid clears.
- Latency: 1 cycle from in_fire (empty buffer) to valid_out. Throughput is 1 transfer per cycle with all consumers ready.
- Ordering: strictly in order across all lanes. A stalled head blocks later requests to other lanes (head-of-line blocking, by design).
- Output stability: while main_valid=1 and out_fire=0, valid_out and data_out hold constant.
- Capacity: 2 entries. ready_in drops the cycle after the skid fills, and rises the cycle after skid drains.
- Simultaneous events:
  - In-range in_fire with out_fire on a full buffer keeps the occupancy at 2.
  - An out-of-range in_fire coincident with out_fire only drains.
- Reset mid-operation: all buffered requests are discarded immediately; no partial transfer is presented after release.
- drop_count is not cleared except by reset.
- Assertions (simulation only):
  - valid_out is one-hot or zero.
  - data_out is stable under stall.
  - skid_valid implies main_valid.

Test Plan:
- Reset then idle, N=4: valid_out=0000, ready_in=1, drop_count=0. Send index=2, data=0xA5 with all ready_out=1: valid_out=0100 and data_out=0xA5 exactly one cycle later, for a single cycle.
- Back-to-back indices 0,1,2,3 (data 0x10..0x13) with all consumers ready: valid_out 0001,0010,0100,1000 on consecutive cycles with matching data, and ready_in held at 1 throughout.
- Lane stall:
  - Stimulus: ready_out[1]=0; send index=1 (0x20), index=3 (0x30), index=0 (0x40).
  - While stalled: valid_out=0010 holds with 0x20, and ready_in=0 after the second accept.
  - Raise ready_out[1]: 0x20 drains, 0x30 on lane 3, then 0x40 on lane 0. No loss and order preserved.
- Out-of-range, N=5, LN=3:
  - Send index=6 then index=4 (0x55).
  - index=6 gives err_out pulse=1 and drop_count=1, with no valid_out for it.
  - index=4 gives valid_out=10000 with 0x55.
- Saturation, CNTW=2: send 5 out-of-range requests; drop_count goes 1,2,3,3,3 and err_out pulses 5 times.
- Async reset asserted mid-cycle with both entries full and lane stalled: valid_out=0 and ready_in=1 immediately; after release, no stale request appears on any lane.
